// File: rtl/mem_resp_unit_if.sv
// rtl/mem_resp_unit_if.sv - request/response bus between a requester and mem_resp_unit
interface mem_resp_unit_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Stall;
    logic        Done;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Stall, Done, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Stall, Done, err
    );
endinterface

// File: rtl/mem_resp_unit.sv
// rtl/mem_resp_unit.sv - fixed-latency word memory with stall/done handshake; MEM_RESP_UNALIGNED_ERR_EN rejects odd addresses
module mem_resp_unit #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_resp_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic [15:0]            data_q;
    logic                   wr_q;
    logic [15:0]            mem [0:(1<<DEPTH_LOG2)-1];

    logic req_one;
    logic req_both;
    logic bad_align;
    logic commit;

    assign req_one  = bus.Rd ^ bus.Wr;
    assign req_both = bus.Rd & bus.Wr;
    assign commit   = (state == BUSY) && (cnt == 4'd0);

`ifdef MEM_RESP_UNALIGNED_ERR_EN
    assign bad_align = bus.Addr[0];
`else
    assign bad_align = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            idx_q       <= '0;
            data_q      <= 16'h0000;
            wr_q        <= 1'b0;
            bus.DataOut <= 16'h0000;
            bus.Stall   <= 1'b0;
            bus.Done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    bus.Done <= 1'b0;
                    if (req_one && !bad_align) begin
                        state     <= BUSY;
                        cnt       <= 4'(LATENCY - 1);
                        idx_q     <= bus.Addr[DEPTH_LOG2:1];
                        data_q    <= bus.DataIn;
                        wr_q      <= bus.Wr;
                        bus.Stall <= 1'b1;
                    end else if (req_both || (req_one && bad_align)) begin
                        bus.err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (commit) begin
                        state     <= DONE;
                        bus.Stall <= 1'b0;
                        bus.Done  <= 1'b1;
                        if (!wr_q) begin
                            bus.DataOut <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.Done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bus.Stall <= 1'b0;
                    bus.Done  <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; gating on rst drops a write whose commit edge lands in reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_resp_unit.sv
// tb/tb_mem_resp_unit.sv - directed self-checking bench for mem_resp_unit (LATENCY 2 and 1 instances)
module tb_mem_resp_unit;

    logic clk;
    logic rst;
    int   cmp_count;
    int   fail_count;

    mem_resp_unit_if bus_a ();
    mem_resp_unit_if bus_b ();

    mem_resp_unit #(.LATENCY(2), .DEPTH_LOG2(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_resp_unit #(.LATENCY(1), .DEPTH_LOG2(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
        bus_a.Rd = rd; bus_a.Wr = wr; bus_a.Addr = addr; bus_a.DataIn = din;
        @(posedge clk);
        #1;
        bus_a.Rd = 1'b0; bus_a.Wr = 1'b0;
    endtask

    task automatic req_b(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
        bus_b.Rd = rd; bus_b.Wr = wr; bus_b.Addr = addr; bus_b.DataIn = din;
        @(posedge clk);
        #1;
        bus_b.Rd = 1'b0; bus_b.Wr = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        cmp_count++;
        if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b000) begin
            fail_count++;
            $display("FAIL reset_ctrl_a: got %b expected 000", {bus_a.Stall, bus_a.Done, bus_a.err});
        end
        cmp_count++;
        if (bus_a.DataOut !== 16'h0000) begin
            fail_count++;
            $display("FAIL reset_dataout_a: got %h expected 0000", bus_a.DataOut);
        end
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done, bus_b.err} !== 3'b000) begin
            fail_count++;
            $display("FAIL reset_ctrl_b: got %b expected 000", {bus_b.Stall, bus_b.Done, bus_b.err});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        logic [2:0] exp;
        req_a(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = (i < 2) ? 3'b100 : (i == 2) ? 3'b010 : 3'b000;
            cmp_count++;
            if ({bus_a.Stall, bus_a.Done, bus_a.err} !== exp) begin
                fail_count++;
                $display("FAIL write_timing[%0d]: got %b expected %b", i, {bus_a.Stall, bus_a.Done, bus_a.err}, exp);
            end
            if (i == 2) begin
                cmp_count++;
                if (bus_a.DataOut !== 16'h0000) begin
                    fail_count++;
                    $display("FAIL write_keeps_dataout: got %h expected 0000", bus_a.DataOut);
                end
            end
        end
        #1;
        req_a(1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = (i < 2) ? 3'b100 : (i == 2) ? 3'b010 : 3'b000;
            cmp_count++;
            if ({bus_a.Stall, bus_a.Done, bus_a.err} !== exp) begin
                fail_count++;
                $display("FAIL read_timing[%0d]: got %b expected %b", i, {bus_a.Stall, bus_a.Done, bus_a.err}, exp);
            end
            if (i == 2) begin
                cmp_count++;
                if (bus_a.DataOut !== 16'hBEEF) begin
                    fail_count++;
                    $display("FAIL read_data: got %h expected beef", bus_a.DataOut);
                end
            end
        end
        #1;
    endtask

    task automatic test_simultaneous;
        req_a(1'b1, 1'b1, 16'h0010, 16'h1111);
        @(negedge clk);
        cmp_count++;
        if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b001) begin
            fail_count++;
            $display("FAIL both_err_pulse: got %b expected 001", {bus_a.Stall, bus_a.Done, bus_a.err});
        end
        @(negedge clk);
        cmp_count++;
        if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b000) begin
            fail_count++;
            $display("FAIL both_err_clear: got %b expected 000", {bus_a.Stall, bus_a.Done, bus_a.err});
        end
        #1;
        req_a(1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_cycles(2);
        cmp_count++;
        if (bus_a.Done !== 1'b1 || bus_a.DataOut !== 16'hBEEF) begin
            fail_count++;
            $display("FAIL both_array_kept: got done=%b data=%h expected done=1 data=beef", bus_a.Done, bus_a.DataOut);
        end
        wait_cycles(1);
    endtask

    task automatic test_reset_mid;
        req_a(1'b0, 1'b1, 16'h0004, 16'h5678);
        wait_cycles(3);
        req_a(1'b0, 1'b1, 16'h0004, 16'h1234);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp_count++;
        if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b000 || bus_a.DataOut !== 16'h0000) begin
            fail_count++;
            $display("FAIL async_reset: got ctrl=%b data=%h expected ctrl=000 data=0000",
                     {bus_a.Stall, bus_a.Done, bus_a.err}, bus_a.DataOut);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_a(1'b1, 1'b0, 16'h0004, 16'h0000);
        wait_cycles(2);
        cmp_count++;
        if (bus_a.Done !== 1'b1 || bus_a.DataOut !== 16'h5678) begin
            fail_count++;
            $display("FAIL reset_abort_write: got done=%b data=%h expected done=1 data=5678", bus_a.Done, bus_a.DataOut);
        end
        wait_cycles(1);
    endtask

    task automatic test_busy_requests;
        int dones;
        dones = 0;
        bus_a.Rd = 1'b1; bus_a.Addr = 16'h0010;
        @(posedge clk);
        #1;
        bus_a.Wr = 1'b1; bus_a.DataIn = 16'hDEAD;
        @(negedge clk);
        cmp_count++;
        if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b100) begin
            fail_count++;
            $display("FAIL busy_ignore_wr: got %b expected 100", {bus_a.Stall, bus_a.Done, bus_a.err});
        end
        @(posedge clk);
        #1;
        bus_a.Wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_a.Done === 1'b1) begin
                dones++;
                cmp_count++;
                if (bus_a.DataOut !== 16'hBEEF) begin
                    fail_count++;
                    $display("FAIL busy_read_data: got %h expected beef", bus_a.DataOut);
                end
                bus_a.Rd = 1'b0;
            end
        end
        cmp_count++;
        if (dones != 1) begin
            fail_count++;
            $display("FAIL busy_done_count: got %0d expected 1", dones);
        end
        #1;
        req_a(1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_cycles(2);
        cmp_count++;
        if (bus_a.DataOut !== 16'hBEEF) begin
            fail_count++;
            $display("FAIL busy_wr_no_effect: got %h expected beef", bus_a.DataOut);
        end
        wait_cycles(1);
    endtask

    task automatic test_unaligned;
        req_a(1'b1, 1'b0, 16'h0011, 16'h0000);
`ifdef MEM_RESP_UNALIGNED_ERR_EN
        @(negedge clk);
        cmp_count++;
        if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b001) begin
            fail_count++;
            $display("FAIL unaligned_err: got %b expected 001", {bus_a.Stall, bus_a.Done, bus_a.err});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_count++;
            if ({bus_a.Stall, bus_a.Done, bus_a.err} !== 3'b000) begin
                fail_count++;
                $display("FAIL unaligned_no_done[%0d]: got %b expected 000", i, {bus_a.Stall, bus_a.Done, bus_a.err});
            end
        end
        #1;
`else
        wait_cycles(2);
        cmp_count++;
        if (bus_a.Done !== 1'b1 || bus_a.err !== 1'b0 || bus_a.DataOut !== 16'hBEEF) begin
            fail_count++;
            $display("FAIL unaligned_service: got done=%b err=%b data=%h expected done=1 err=0 data=beef",
                     bus_a.Done, bus_a.err, bus_a.DataOut);
        end
        wait_cycles(1);
`endif
    endtask

    task automatic test_back_to_back;
        req_b(1'b0, 1'b1, 16'h0020, 16'hA5A5);
        wait_cycles(2);
        req_b(1'b0, 1'b1, 16'h0022, 16'h5A5A);
        wait_cycles(2);
        req_b(1'b1, 1'b0, 16'h0020, 16'h0000);
        @(negedge clk);
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done} !== 2'b10) begin
            fail_count++;
            $display("FAIL b2b_first_stall: got %b expected 10", {bus_b.Stall, bus_b.Done});
        end
        @(negedge clk);
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done} !== 2'b01 || bus_b.DataOut !== 16'hA5A5) begin
            fail_count++;
            $display("FAIL b2b_first_done: got ctrl=%b data=%h expected ctrl=01 data=a5a5",
                     {bus_b.Stall, bus_b.Done}, bus_b.DataOut);
        end
        bus_b.Rd = 1'b1; bus_b.Addr = 16'h0022;
        @(negedge clk);
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done} !== 2'b00) begin
            fail_count++;
            $display("FAIL b2b_idle_gap: got %b expected 00", {bus_b.Stall, bus_b.Done});
        end
        @(posedge clk);
        #1;
        bus_b.Rd = 1'b0;
        @(negedge clk);
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done} !== 2'b10) begin
            fail_count++;
            $display("FAIL b2b_second_stall: got %b expected 10", {bus_b.Stall, bus_b.Done});
        end
        @(negedge clk);
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done} !== 2'b01 || bus_b.DataOut !== 16'h5A5A) begin
            fail_count++;
            $display("FAIL b2b_second_done: got ctrl=%b data=%h expected ctrl=01 data=5a5a",
                     {bus_b.Stall, bus_b.Done}, bus_b.DataOut);
        end
        @(negedge clk);
        cmp_count++;
        if ({bus_b.Stall, bus_b.Done} !== 2'b00) begin
            fail_count++;
            $display("FAIL b2b_end_idle: got %b expected 00", {bus_b.Stall, bus_b.Done});
        end
    endtask

    initial begin
        cmp_count  = 0;
        fail_count = 0;
        rst = 1'b1;
        bus_a.Rd = 1'b0; bus_a.Wr = 1'b0; bus_a.Addr = 16'h0000; bus_a.DataIn = 16'h0000;
        bus_b.Rd = 1'b0; bus_b.Wr = 1'b0; bus_b.Addr = 16'h0000; bus_b.DataIn = 16'h0000;
        test_reset;
        test_write_read;
        test_simultaneous;
        test_reset_mid;
        test_busy_requests;
        test_unaligned;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
